// File: rtl/i2s_stream_tx.sv
// i2s_stream_tx: framed serial pixel stream (16-bit header + N data bits) with one-byte prefetch buffer.
// Optional I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun byte counter output.
module i2s_stream_tx (
  input  logic       i2s_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] num_modules_x,
  input  logic [3:0] num_modules_y,
  input  logic [5:0] row_num,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       i2s_data,
  output logic       busy,
  output logic       done,
  output logic       underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0] underrun_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t      state_q, state_d;
  logic [1:0]  rs_q;
  logic        rst_ok;
  logic [11:0] cnt_q, cnt_d, last;
  logic [3:0]  nx_q, ny_q;
  logic [8:0]  mods;
  logic [15:0] hdr_w, hsr_q, hsr_d;
  logic [7:0]  sr_q, sr_d, hold_q, hold_d, ld_byte, urc_q, urc_d;
  logic        hold_v_q, hold_v_d, data_q, data_d, done_q, done_d, ur_q, ur_d;
  logic        idle, last_bit, hdr_last, go, reload, accept, uflow, clr;
  // Reset asserts immediately but releases two edges later so logic starts from a clean IDLE.
  always_ff @(posedge i2s_clk or negedge rst_n)
    if (!rst_n) rs_q <= '0;
    else rs_q <= {rs_q[0], 1'b1};
  assign rst_ok = rs_q[1];
  assign mods     = (9'(nx_q) + 9'd1) * (9'(ny_q) + 9'd1);
  assign last     = 12'({mods, 4'b0000} - 13'd1);
  assign hdr_w    = {num_modules_x, num_modules_y, 2'b00, row_num};
  assign idle     = state_q == IDLE;
  assign last_bit = state_q == DATA && cnt_q == last;
  assign hdr_last = state_q == HDR && cnt_q == 12'd15;
  assign go       = start & (idle | last_bit);
  assign reload   = hdr_last | (state_q == DATA && !last_bit && cnt_q[2:0] == 3'd7);
  assign accept   = pix_valid & ~hold_v_q;
  assign uflow    = reload & ~hold_v_q;
  assign clr      = go & idle;
  assign ld_byte  = hold_v_q ? hold_q : 8'h00;
  always_ff @(posedge i2s_clk or negedge rst_ok)
    if (!rst_ok) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = go ? HDR : hdr_last ? DATA : last_bit ? IDLE : state_q;
  always_comb begin
    cnt_d    = (go || hdr_last || idle || last_bit) ? 12'd0 : cnt_q + 12'd1;
    data_d   = go ? hdr_w[15] : reload ? ld_byte[7] : (state_q == HDR) ? hsr_q[15] :
               (state_q == DATA && !last_bit) ? sr_q[7] : 1'b0;
    hsr_d    = go ? {hdr_w[14:0], 1'b0} : {hsr_q[14:0], 1'b0};
    sr_d     = reload ? {ld_byte[6:0], 1'b0} : {sr_q[6:0], 1'b0};
    hold_v_d = accept | (hold_v_q & ~reload);
    hold_d   = accept ? pix_data : hold_q;
    done_d   = state_q == DATA && cnt_q == last - 12'd1;
    ur_d     = !clr && (ur_q || uflow);
    urc_d    = clr ? 8'd0 : (uflow && urc_q != 8'hFF) ? urc_q + 8'd1 : urc_q;
  end
  always_ff @(posedge i2s_clk or negedge rst_ok)
    if (!rst_ok) begin
      cnt_q    <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      hsr_q    <= '0;
      sr_q     <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      data_q   <= 1'b0;
      done_q   <= 1'b0;
      ur_q     <= 1'b0;
      urc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      nx_q     <= go ? num_modules_x : nx_q;
      ny_q     <= go ? num_modules_y : ny_q;
      hsr_q    <= hsr_d;
      sr_q     <= sr_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      data_q   <= data_d;
      done_q   <= done_d;
      ur_q     <= ur_d;
      urc_q    <= urc_d;
    end
  assign pix_ready = ~hold_v_q;
  assign i2s_data  = data_q;
  assign busy      = ~idle;
  assign done      = done_q;
  assign underrun  = ur_q;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  assign underrun_cnt = urc_q;
`else
  logic unused;
  assign unused = ^urc_q;
`endif
endmodule

// File: tb/tb_i2s_stream_tx.sv
// tb_i2s_stream_tx: directed frame tests with hand-computed header/data bit streams.
module tb_i2s_stream_tx;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic [3:0] nx = '0, ny = '0;
  logic [5:0] row = '0;
  logic [7:0] pix_data = '0;
  logic       pix_ready, i2s_data, busy, done, underrun;
  int         total = 0, bad = 0;
  logic       rec_d[$], exp_q[$];
  bit         rec_b[$], rec_n[$];
  logic [7:0] fq[$];
  int         nb, nd, ld;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif
  i2s_stream_tx dut (
    .i2s_clk(clk), .rst_n(rst_n), .start(start),
    .num_modules_x(nx), .num_modules_y(ny), .row_num(row),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .i2s_data(i2s_data), .busy(busy), .done(done), .underrun(underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rec_d.push_back(i2s_data);
      rec_b.push_back(busy);
      rec_n.push_back(done);
      if (pix_ready && fq.size() > 0) begin
        pix_valid = 1'b1;
        pix_data  = fq.pop_front();
      end else pix_valid = 1'b0;
    end
  endtask
  task automatic clear();
    rec_d.delete(); rec_b.delete(); rec_n.delete(); exp_q.delete();
  endtask
  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
  endtask
  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask
  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
  endtask
  task automatic cmp_bits(input string tag, input int n);
    int errs = 0;
    for (int i = 0; i < n; i++)
      if (i >= rec_d.size() || rec_d[i] !== exp_q[i]) errs++;
    chk(tag, errs, 0);
  endtask
  task automatic stats(output int b, output int d, output int l);
    b = 0; d = 0; l = -1;
    for (int i = 0; i < rec_b.size(); i++) begin
      b += int'(rec_b[i]);
      if (rec_n[i]) begin d++; l = i; end
    end
  endtask
  task automatic do_reset();
    pix_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data", i2s_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", pix_ready, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("rst_ucnt", underrun_cnt, 0);
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    // single-module frame with both bytes prefetched/streamed
    fq = {8'hA5, 8'h3C};
    run(3);
    chk("t1_prefetch_ready", pix_ready, 0);
    nx = 0; ny = 0; row = 5; start = 1'b1;
    clear();
    run(1);
    start = 1'b0;
    run(39);
    push_word(16'h0005); push_word(16'hA53C); push_zeros(8);
    cmp_bits("t1_bits", 40);
    stats(nb, nd, ld);
    chk("t1_busy_cycles", nb, 32);
    chk("t1_done_cnt", nd, 1);
    chk("t1_done_at", ld, 31);
    chk("t1_underrun", underrun, 0);
    chk("t1_idle_busy", busy, 0);
    // 4x4 modules with continuous supply; one extra byte stays buffered
    for (int i = 0; i < 40; i++) fq.push_back(8'(i + 1));
    run(2);
    nx = 3; ny = 3; row = 6'h2A; start = 1'b1;
    clear();
    run(1);
    start = 1'b0;
    run(279);
    push_word(16'h332A);
    for (int i = 1; i <= 32; i++) push_byte(8'(i));
    push_zeros(8);
    cmp_bits("t2_bits", 280);
    stats(nb, nd, ld);
    chk("t2_busy_cycles", nb, 272);
    chk("t2_done_at", ld, 271);
    chk("t2_underrun", underrun, 0);
    chk("t2_bytes_taken", fq.size(), 7);
    chk("t2_leftover_ready", pix_ready, 0);
    // leftover byte only, second byte underruns; a mid-frame start is ignored
    fq.delete();
    nx = 0; ny = 0; row = 6'h3F; start = 1'b1;
    clear();
    run(1);
    start = 1'b0;
    run(9);
    start = 1'b1;
    run(1);
    start = 1'b0;
    run(29);
    push_word(16'h003F); push_byte(8'h21); push_byte(8'h00); push_zeros(8);
    cmp_bits("t3_bits", 40);
    stats(nb, nd, ld);
    chk("t3_busy_cycles", nb, 32);
    chk("t3_underrun", underrun, 1);
    run(5);
    chk("t3_underrun_sticky", underrun, 1);
    // start held across two frames: back-to-back with no idle cycle
    for (int i = 0; i < 12; i++) fq.push_back(8'hC0 + 8'(i));
    run(2);
    nx = 1; ny = 0; row = 7; start = 1'b1;
    clear();
    run(1);
    chk("t4_underrun_cleared", underrun, 0);
    run(47);
    run(1);
    start = 1'b0;
    run(52);
    push_word(16'h1007);
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    push_word(16'h1007);
    for (int i = 4; i < 8; i++) push_byte(8'hC0 + 8'(i));
    push_zeros(5);
    cmp_bits("t4_bits", 101);
    stats(nb, nd, ld);
    chk("t4_busy_cycles", nb, 96);
    chk("t4_done_cnt", nd, 2);
    chk("t4_done_at", ld, 95);
    chk("t4_underrun", underrun, 0);
    // reset during data bit 100 of a 4x4 frame, then a clean full frame
    fq.delete();
    for (int i = 0; i < 40; i++) fq.push_back(8'h40 + 8'(i));
    nx = 3; ny = 3; row = 1; start = 1'b1;
    clear();
    run(1);
    start = 1'b0;
    run(116);
    push_word(16'h3301); push_byte(8'hC8);
    for (int i = 0; i < 13; i++) push_byte(8'h40 + 8'(i));
    cmp_bits("t5_prefix_bits", 117);
    stats(nb, nd, ld);
    chk("t5_no_done", nd, 0);
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data", i2s_data, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_ready", pix_ready, 1);
    do_reset();
    fq.delete();
    for (int i = 0; i < 40; i++) fq.push_back(8'h60 + 8'(i));
    run(2);
    row = 2; start = 1'b1;
    clear();
    run(1);
    start = 1'b0;
    run(279);
    push_word(16'h3302);
    for (int i = 0; i < 32; i++) push_byte(8'h60 + 8'(i));
    push_zeros(8);
    cmp_bits("t5_bits", 280);
    stats(nb, nd, ld);
    chk("t5_busy_cycles", nb, 272);
    chk("t5_done_at", ld, 271);
    chk("t5_underrun", underrun, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    fq.delete();
    nx = 15; ny = 15; row = 0; start = 1'b1;
    clear();
    run(1);
    start = 1'b0;
    run(4120);
    chk("t6_underrun", underrun, 1);
    chk("t6_ucnt_sat", underrun_cnt, 8'd255);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2s_stream_tx.md
I2S_STREAM_TX -- requirements
Module: i2s_stream_tx

Interface
REQ-001 The port list SHALL be as follows (REQ-002 to REQ-014); one clock; reset is asynchronous and active-low.
REQ-002 i2s_clk  input  1  stream bit clock; all state on rising edge.
REQ-003 rst_n  input  1  async active-low reset.
REQ-004 start  input  1  request one frame; sampled when idle or on last data bit.
REQ-005 num_modules_x  input  4  module columns minus 1; latched on accepted start.
REQ-006 num_modules_y  input  4  module rows minus 1; latched on accepted start.
REQ-007 row_num  input  6  panel row for this frame; latched on accepted start.
REQ-008 pix_data  input  8  pixel byte, MSB sent first.
REQ-009 pix_valid  input  1  pix_data valid.
REQ-010 pix_ready  output  1  byte accepted when pix_valid & pix_ready at a rising edge.
REQ-011 i2s_data  output  1  serial stream, registered.
REQ-012 busy  output  1  high in HDR or DATA state.
REQ-013 done  output  1  one-cycle pulse coincident with the edge that launches the last data bit.
REQ-014 underrun  output  1  sticky: a data byte was needed but not buffered.

Function
REQ-015 States SHALL be IDLE, HDR, DATA; IDLE->HDR on start; HDR->DATA after 16 header bits; DATA->HDR if start high on last-bit edge, else DATA->IDLE.
REQ-016 Accepted start SHALL launch header bit 0 on i2s_data at the same edge; no gap cycles between any bits or back-to-back frames.
REQ-017 Header SHALL be 16 bits, MSB-first per field: bits 0-3 num_modules_x, 4-7 num_modules_y, 8-9 zero, 10-15 row_num.
REQ-018 Data length SHALL be N = 16*(nx+1)*(ny+1) bits (16..4096) using a 12-bit bit counter 0..N-1; byte count N/8.
REQ-019 Buffering SHALL be shift register plus one holding register; pix_ready = holding register empty, in any state including IDLE and HDR (prefetch).
REQ-020 Shift register SHALL reload from holding register at data bit 0 and every 8th bit; a same-edge reload and new accept SHALL both succeed.
REQ-021 If reload occurs with holding empty, the byte SHALL be sent as 0x00 and underrun set; stream timing never stalls.
REQ-022 underrun SHALL clear only on reset or an accepted start from IDLE.
REQ-023 i2s_data SHALL be 0 in IDLE; start while busy (except last-bit edge) SHALL be ignored.
REQ-024 Bytes left in the holding register at frame end SHALL remain for the next frame.

Reset
REQ-025 On rst_n low, immediately: state IDLE, i2s_data 0, busy 0, done 0, underrun 0, pix_ready 1, buffers empty, counters 0; reset mid-frame aborts the frame with no done.
REQ-026 Release SHALL be synchronised so the first active edge sees a clean IDLE.

Configuration
REQ-027 Macro I2S_TX_UNDERRUN_CNT_EN: when defined, adds output underrun_cnt (8 bits) counting underrun bytes, saturating at 255, cleared with underrun; when undefined, port and counter absent, behaviour otherwise identical.

Verification
REQ-028 nx=0, ny=0, row=5, start, bytes 0xA5,0x3C prefetched -> header 0000_0000_00_000101, data 1010010100111100, done on bit 15, then IDLE, i2s_data 0.
REQ-029 nx=3, ny=3, continuous pix_valid -> 16+256 bits, 32 bytes accepted, underrun 0, busy high exactly 272 cycles.
REQ-030 nx=0, ny=0, only one byte supplied -> second byte sent as 0x00, underrun 1 until next start.
REQ-031 start held high across frames, nx=1, ny=0 -> header of frame 2 begins the cycle after last data bit; no idle cycle.
REQ-032 rst_n low at data bit 100 of nx=3, ny=3 frame -> outputs to reset values immediately, no done; new start gives a correct full frame.
REQ-033 With I2S_TX_UNDERRUN_CNT_EN, nx=15, ny=15, no bytes supplied -> underrun_cnt saturates at 255.
